// File: rtl/demux_8_reg_pkg.sv
// Shared constants and lane state type for the 8-lane write-side demux.
// Also holds the popcount helper used by the occupancy counter.
package demux_8_reg_pkg;

  localparam int unsigned NUM_LANES = 8;
  localparam int unsigned SEL_WIDTH = 3;
  localparam int unsigned OCC_WIDTH = 4;

  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_e;

  function automatic logic [OCC_WIDTH-1:0] popcount_lanes(
    input logic [NUM_LANES-1:0] v
  );
    logic [OCC_WIDTH-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      cnt = cnt + OCC_WIDTH'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/demux_8_reg_decoder_3to8.sv
// Enabled 3-to-8 one-hot decoder; produces all zeros while disabled.
module decoder_3to8
  import demux_8_reg_pkg::*;
(
  input  logic [SEL_WIDTH-1:0] sel_i,
  input  logic                 en_i,
  output logic [NUM_LANES-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o = NUM_LANES'(1) << sel_i;
    end
  end

endmodule

// File: rtl/demux_8_reg.sv
// Steers one source word into one of 8 holding lanes with per-lane valid flags,
// a valid/ready source handshake and per-lane consume-to-clear.
module demux_8_reg
  import demux_8_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [SEL_WIDTH-1:0]       in_select,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic [NUM_LANES-1:0]       out_consume,
  output logic [NUM_LANES-1:0]       out_valid,
  output logic [NUM_LANES*WIDTH-1:0] out_data,
  output logic [OCC_WIDTH-1:0]       occupancy
);

  lane_state_e          lane_q [NUM_LANES];
  lane_state_e          lane_d [NUM_LANES];
  logic [WIDTH-1:0]     data_q [NUM_LANES];
  logic [WIDTH-1:0]     data_d [NUM_LANES];
  logic [OCC_WIDTH-1:0] occ_q;
  logic [OCC_WIDTH-1:0] occ_d;
  logic [NUM_LANES-1:0] wr_stb;
  logic [NUM_LANES-1:0] clr_eff;
  logic                 fill_empty;

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      out_valid[i]               = (lane_q[i] == LANE_FULL);
      out_data[i*WIDTH +: WIDTH] = data_q[i];
    end
  end

  assign occupancy = occ_q;

  // A lane being drained this cycle can take a new word in the same cycle.
  assign in_ready = ~out_valid[in_select] | out_consume[in_select];

  decoder_3to8 u_dec (
    .sel_i    (in_select),
    .en_i     (in_valid & in_ready),
    .onehot_o (wr_stb)
  );

  // A write on a lane overrides a same-cycle consume of that lane.
  assign clr_eff    = out_consume & out_valid & ~wr_stb;
  assign fill_empty = |(wr_stb & ~out_valid);

  always_comb begin
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      lane_d[i] = lane_q[i];
      data_d[i] = data_q[i];
      if (wr_stb[i]) begin
        lane_d[i] = LANE_FULL;
        data_d[i] = in_data;
      end else if (clr_eff[i]) begin
        lane_d[i] = LANE_EMPTY;
      end
    end
    occ_d = occ_q + OCC_WIDTH'(fill_empty) - popcount_lanes(clr_eff);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        lane_q[i] <= LANE_EMPTY;
        data_q[i] <= '0;
      end
      occ_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        lane_q[i] <= lane_d[i];
        data_q[i] <= data_d[i];
      end
      occ_q <= occ_d;
    end
  end

endmodule

// File: tb/tb_demux_8_reg.sv
// Directed self-checking bench for demux_8_reg.
module tb_demux_8_reg;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic [2:0]   in_select;
  logic [31:0]  in_data;
  logic         in_ready;
  logic [7:0]   out_consume;
  logic [7:0]   out_valid;
  logic [255:0] out_data;
  logic [3:0]   occupancy;

  int checks = 0;
  int errors = 0;

  demux_8_reg #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_select   (in_select),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_consume (out_consume),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .occupancy   (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] lane(input int unsigned l);
    return out_data[l*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_lane(input logic [2:0] sel, input logic [31:0] d);
    in_valid  = 1'b1;
    in_select = sel;
    in_data   = d;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 8'h00) begin
      errors++; $display("FAIL reset_valid: got %h expected %h", out_valid, 8'h00);
    end
    checks++;
    if (occupancy !== 4'd0) begin
      errors++; $display("FAIL reset_occ: got %0d expected %0d", occupancy, 0);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (lane(i) !== 32'h0) begin
        errors++; $display("FAIL reset_lane%0d: got %h expected %h", i, lane(i), 32'h0);
      end
      in_select = 3'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL empty_ready_sel%0d: got %b expected %b", i, in_ready, 1'b1);
      end
    end
  endtask

  task automatic test_single_write();
    write_lane(3'd5, 32'hDEADBEEF);
    checks++;
    if (out_valid !== 8'h20) begin
      errors++; $display("FAIL single_valid: got %h expected %h", out_valid, 8'h20);
    end
    checks++;
    if (lane(5) !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_lane5: got %h expected %h", lane(5), 32'hDEADBEEF);
    end
    checks++;
    if (occupancy !== 4'd1) begin
      errors++; $display("FAIL single_occ: got %0d expected %0d", occupancy, 1);
    end
    out_consume = 8'h20;
    tick();
    out_consume = 8'h00;
    checks++;
    if (out_valid !== 8'h00) begin
      errors++; $display("FAIL consume_valid: got %h expected %h", out_valid, 8'h00);
    end
    checks++;
    if (lane(5) !== 32'hDEADBEEF) begin
      errors++; $display("FAIL consume_stale5: got %h expected %h", lane(5), 32'hDEADBEEF);
    end
    checks++;
    if (occupancy !== 4'd0) begin
      errors++; $display("FAIL consume_occ: got %0d expected %0d", occupancy, 0);
    end
  endtask

  task automatic test_backpressure();
    write_lane(3'd2, 32'hAAAA5555);
    in_valid  = 1'b1;
    in_select = 3'd2;
    in_data   = 32'h1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_ready: got %b expected %b", in_ready, 1'b0);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (lane(2) !== 32'hAAAA5555 || in_ready !== 1'b0 || occupancy !== 4'd1) begin
        errors++;
        $display("FAIL bp_hold_c%0d: got lane2=%h ready=%b occ=%0d expected lane2=%h ready=0 occ=1",
                 c, lane(2), in_ready, occupancy, 32'hAAAA5555);
      end
    end
    out_consume = 8'h04;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got %b expected %b", in_ready, 1'b1);
    end
    tick();
    in_valid    = 1'b0;
    out_consume = 8'h00;
    checks++;
    if (lane(2) !== 32'h1 || out_valid !== 8'h04 || occupancy !== 4'd1) begin
      errors++;
      $display("FAIL bp_overwrite: got lane2=%h valid=%h occ=%0d expected lane2=1 valid=04 occ=1",
               lane(2), out_valid, occupancy);
    end
    out_consume = 8'h04;
    tick();
    out_consume = 8'h00;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) write_lane(3'(i), 32'(i + 100));
    checks++;
    if (out_valid !== 8'hFF || occupancy !== 4'd8) begin
      errors++; $display("FAIL fill: got valid=%h occ=%0d expected valid=ff occ=8", out_valid, occupancy);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (lane(i) !== 32'(i + 100)) begin
        errors++; $display("FAIL fill_lane%0d: got %0d expected %0d", i, lane(i), i + 100);
      end
    end
    in_valid  = 1'b1;
    in_select = 3'd3;
    in_data   = 32'h333;
    out_consume = 8'h08;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL full_consume_ready: got %b expected %b", in_ready, 1'b1);
    end
    out_consume = 8'h00;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready: got %b expected %b", in_ready, 1'b0);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (lane(3) !== 32'd103 || occupancy !== 4'd8) begin
      errors++; $display("FAIL full_nowrite: got lane3=%0d occ=%0d expected lane3=103 occ=8", lane(3), occupancy);
    end
    out_consume = 8'hFF;
    tick();
    out_consume = 8'h00;
    checks++;
    if (out_valid !== 8'h00 || occupancy !== 4'd0) begin
      errors++; $display("FAIL drain_all: got valid=%h occ=%0d expected valid=00 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_concurrent();
    write_lane(3'd0, 32'h10);
    write_lane(3'd1, 32'h11);
    in_valid    = 1'b1;
    in_select   = 3'd4;
    in_data     = 32'h44;
    out_consume = 8'h03;
    tick();
    in_valid    = 1'b0;
    out_consume = 8'h00;
    checks++;
    if (out_valid !== 8'h10 || occupancy !== 4'd1 || lane(4) !== 32'h44 || lane(0) !== 32'h10) begin
      errors++;
      $display("FAIL concurrent: got valid=%h occ=%0d lane4=%h lane0=%h expected valid=10 occ=1 lane4=44 lane0=10",
               out_valid, occupancy, lane(4), lane(0));
    end
    out_consume = 8'h80;
    tick();
    out_consume = 8'h00;
    checks++;
    if (out_valid !== 8'h10 || occupancy !== 4'd1) begin
      errors++; $display("FAIL empty_consume: got valid=%h occ=%0d expected valid=10 occ=1", out_valid, occupancy);
    end
    in_valid    = 1'b1;
    in_select   = 3'd4;
    in_data     = 32'h55;
    out_consume = 8'h10;
    tick();
    in_valid    = 1'b0;
    out_consume = 8'h00;
    checks++;
    if (out_valid !== 8'h10 || occupancy !== 4'd1 || lane(4) !== 32'h55) begin
      errors++;
      $display("FAIL write_wins: got valid=%h occ=%0d lane4=%h expected valid=10 occ=1 lane4=55",
               out_valid, occupancy, lane(4));
    end
  endtask

  task automatic test_reset_mid();
    write_lane(3'd0, 32'hA0);
    write_lane(3'd1, 32'hA1);
    write_lane(3'd6, 32'hA6);
    checks++;
    if (out_valid !== 8'h53 || occupancy !== 4'd4) begin
      errors++; $display("FAIL pre_reset: got valid=%h occ=%0d expected valid=53 occ=4", out_valid, occupancy);
    end
    in_valid  = 1'b1;
    in_select = 3'd2;
    in_data   = 32'h77;
    reset     = 1'b0;
    tick();
    reset    = 1'b1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 8'h00 || occupancy !== 4'd0) begin
      errors++; $display("FAIL midreset: got valid=%h occ=%0d expected valid=00 occ=0", out_valid, occupancy);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (lane(i) !== 32'h0) begin
        errors++; $display("FAIL midreset_lane%0d: got %h expected %h", i, lane(i), 32'h0);
      end
    end
  endtask

  initial begin
    reset       = 1'b0;
    in_valid    = 1'b0;
    in_select   = 3'd0;
    in_data     = 32'h0;
    out_consume = 8'h00;
    test_reset();
    test_single_write();
    test_backpressure();
    test_fill();
    test_concurrent();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
